// File: rtl/fan_pwm_sequencer.sv
// Fan PWM sequencer: debounced speed request, kick-start at full duty,
// then a stepped ramp to the requested duty with boundary-aligned updates.
module fan_pwm_sequencer #(
    parameter int PrescDiv      = 125,
    parameter int KickPeriods   = 2500,
    parameter int RampPeriods   = 16,
    parameter int DebounceTicks = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] pwm_setting_i,
    output logic       fan_pwm_o,
    output logic [3:0] duty_o,
    output logic [1:0] state_o,
    output logic       busy_o
);

    localparam int PW = $clog2(PrescDiv);
    localparam int KW = $clog2(KickPeriods + 1);
    localparam int RW = $clog2(RampPeriods + 1);
    localparam int DW = $clog2(DebounceTicks + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(PrescDiv - 1);
    localparam logic [KW-1:0] KICK_MAX  = KW'(KickPeriods - 1);
    localparam logic [RW-1:0] RAMP_MAX  = RW'(RampPeriods - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DebounceTicks - 1);
    localparam logic [DW-1:0] DEB_SAT   = DW'(DebounceTicks);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] KICK = 2'd1;
    localparam logic [1:0] RAMP = 2'd2;
    localparam logic [1:0] RUN  = 2'd3;

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    pwm_cnt_q;
    logic [3:0]    cand_q;
    logic [DW-1:0] deb_cnt_q;
    logic [3:0]    target_q;
    logic [3:0]    duty_q;
    logic [1:0]    state_q;
    logic [KW-1:0] kick_cnt_q;
    logic [RW-1:0] ramp_cnt_q;
    logic          fan_q;
    logic          tick;
    logic          boundary;
    logic [3:0]    step_duty;

    assign tick     = (presc_q == PRESC_MAX);
    assign boundary = tick && (pwm_cnt_q == 4'd15);

    always_comb begin
        step_duty = duty_q;
        if (target_q > duty_q) begin
            step_duty = duty_q + 4'd1;
        end else if (target_q < duty_q) begin
            step_duty = duty_q - 4'd1;
        end
    end

    // Request path: 2-flop sync, then accept only after it holds still.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            cand_q    <= '0;
            deb_cnt_q <= '0;
            target_q  <= '0;
        end else begin
            sync1_q <= pwm_setting_i;
            sync2_q <= sync1_q;
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                pwm_cnt_q <= pwm_cnt_q + 4'd1;
                if (sync2_q != cand_q) begin
                    cand_q    <= sync2_q;
                    deb_cnt_q <= '0;
                end else if (deb_cnt_q != DEB_SAT) begin
                    deb_cnt_q <= deb_cnt_q + 1'b1;
                    if (deb_cnt_q == DEB_LAST) begin
                        target_q <= cand_q;
                    end
                end
            end
        end
    end

    // All duty and state changes land on a period boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            kick_cnt_q <= '0;
            ramp_cnt_q <= '0;
        end else if (boundary) begin
            unique case (state_q)
                IDLE: begin
                    if (target_q != 4'd0) begin
                        state_q    <= KICK;
                        duty_q     <= 4'd15;
                        kick_cnt_q <= '0;
                    end
                end
                KICK: begin
                    if (target_q == 4'd0) begin
                        state_q <= IDLE;
                        duty_q  <= 4'd0;
                    end else if (kick_cnt_q == KICK_MAX) begin
                        state_q    <= RAMP;
                        ramp_cnt_q <= '0;
                    end else begin
                        kick_cnt_q <= kick_cnt_q + 1'b1;
                    end
                end
                RAMP: begin
                    if (duty_q == target_q) begin
                        state_q <= (target_q == 4'd0) ? IDLE : RUN;
                    end else if (ramp_cnt_q == RAMP_MAX) begin
                        ramp_cnt_q <= '0;
                        duty_q     <= step_duty;
                        if (step_duty == target_q) begin
                            state_q <= (target_q == 4'd0) ? IDLE : RUN;
                        end
                    end else begin
                        ramp_cnt_q <= ramp_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (target_q != duty_q) begin
                        state_q    <= RAMP;
                        ramp_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fan_q <= 1'b0;
        end else begin
            fan_q <= (duty_q == 4'd15) || (pwm_cnt_q < duty_q);
        end
    end

    assign fan_pwm_o = fan_q;
    assign duty_o    = duty_q;
    assign state_o   = state_q;
    assign busy_o    = (state_q == KICK) || (state_q == RAMP);

endmodule

// File: tb/tb_fan_pwm_sequencer.sv
// Directed bench for fan_pwm_sequencer: expected duty changes are queued
// as each request is applied and checked as the DUT moves duty_o.
module tb_fan_pwm_sequencer;

    localparam int PER = 32;

    typedef struct {
        logic [3:0] d;
        int         dt;
    } exp_t;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] pwm_setting_i;
    logic       fan_pwm_o;
    logic [3:0] duty_o;
    logic [1:0] state_o;
    logic       busy_o;

    int         total;
    int         bad;
    int         cyc;
    int         t_ref;
    int         t_prev;
    logic [3:0] last_duty;
    logic       saw_kick;
    exp_t       exp_q[$];

    fan_pwm_sequencer #(
        .PrescDiv(2),
        .KickPeriods(3),
        .RampPeriods(2),
        .DebounceTicks(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .pwm_setting_i(pwm_setting_i),
        .fan_pwm_o(fan_pwm_o),
        .duty_o(duty_o),
        .state_o(state_o),
        .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input int dt);
        exp_t e;
        e.d  = d;
        e.dt = dt;
        exp_q.push_back(e);
    endtask

    task automatic wait_change(input int lim);
        int   n;
        int   t;
        exp_t e;
        n = 0;
        while (duty_o === last_duty && n < lim) begin
            @(negedge clk_i);
            n++;
            if (state_o === 2'd1) saw_kick = 1'b1;
        end
        chk("duty_moved", 32'(duty_o !== last_duty), 1);
        t = cyc;
        last_duty = duty_o;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("duty", 32'(duty_o), 32'(e.d));
            if (e.dt != 0) chk("step_dt", t - t_prev, e.dt);
            if (e.d == 4'd15 && state_o === 2'd1) t_ref = t;
            else chk("align", (t - t_ref) % PER, 0);
        end
        t_prev = t;
    endtask

    task automatic count_hi(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk_i);
            if (fan_pwm_o === 1'b1) c++;
        end
    endtask

    initial begin
        int         hi;
        int         errs;
        logic [1:0] st_mid;
        total = 0;
        bad = 0;
        t_ref = 0;
        t_prev = 0;
        saw_kick = 1'b0;
        last_duty = 4'd0;
        rst_i = 1'b1;
        pwm_setting_i = 4'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_fan", 32'(fan_pwm_o), 0);
        chk("rst_duty", 32'(duty_o), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst_i = 1'b0;

        errs = 0;
        repeat (500) begin
            @(negedge clk_i);
            if (fan_pwm_o !== 1'b0 || state_o !== 2'd0 || duty_o !== 4'd0)
                errs++;
        end
        chk("idle_hold", errs, 0);

        pwm_setting_i = 4'd8;
        push(4'd15, 0);
        push(4'd14, 160);
        for (int d = 13; d >= 8; d--) push(4'(d), 64);
        wait_change(200);
        chk("kick_state", 32'(state_o), 1);
        chk("kick_busy", 32'(busy_o), 1);
        hi = 0;
        st_mid = 2'd0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk_i);
            if (fan_pwm_o === 1'b1) hi++;
            if (i == 94) st_mid = state_o;
        end
        chk("kick_hi", hi, 96);
        chk("kick_last", 32'(st_mid), 1);
        chk("ramp_entry", 32'(state_o), 2);
        repeat (7) wait_change(200);
        chk("run8_state", 32'(state_o), 3);
        chk("run8_busy", 32'(busy_o), 0);
        repeat (PER) @(negedge clk_i);
        count_hi(PER, hi);
        chk("run8_hi", hi, 16);

        pwm_setting_i = 4'd3;
        repeat (2) @(negedge clk_i);
        pwm_setting_i = 4'd8;
        errs = 0;
        repeat (200) begin
            @(negedge clk_i);
            if (state_o !== 2'd3 || duty_o !== 4'd8) errs++;
        end
        chk("glitch", errs, 0);

        saw_kick = 1'b0;
        pwm_setting_i = 4'd12;
        push(4'd9, 0);
        push(4'd10, 64);
        push(4'd11, 64);
        repeat (3) wait_change(300);
        chk("up_no_kick", 32'(saw_kick), 0);
        chk("up_state", 32'(state_o), 2);
        chk("up_busy", 32'(busy_o), 1);

        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_fan", 32'(fan_pwm_o), 0);
        chk("mid_rst_duty", 32'(duty_o), 0);
        chk("mid_rst_state", 32'(state_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        rst_i = 1'b0;
        last_duty = 4'd0;
        push(4'd15, 0);
        push(4'd14, 160);
        push(4'd13, 64);
        push(4'd12, 64);
        wait_change(200);
        chk("rekick_state", 32'(state_o), 1);
        repeat (3) wait_change(300);
        chk("run12_state", 32'(state_o), 3);
        repeat (PER) @(negedge clk_i);
        count_hi(PER, hi);
        chk("run12_hi", hi, 24);

        pwm_setting_i = 4'd0;
        push(4'd11, 0);
        for (int d = 10; d >= 0; d--) push(4'(d), 64);
        repeat (12) wait_change(300);
        chk("down_state", 32'(state_o), 0);
        chk("down_busy", 32'(busy_o), 0);
        @(negedge clk_i);
        count_hi(PER, hi);
        chk("down_hi", hi, 0);

        pwm_setting_i = 4'd5;
        push(4'd15, 0);
        wait_change(200);
        chk("abort_kick", 32'(state_o), 1);
        pwm_setting_i = 4'd0;
        push(4'd0, 0);
        wait_change(100);
        chk("abort_state", 32'(state_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        @(negedge clk_i);
        chk("abort_fan", 32'(fan_pwm_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
